// File: rtl/decoder_pkg.sv
// Shared types and helpers for the scan decoder block.
// State encodings, mode constants and the counter-width function.
package decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Dwell counter never narrower than one bit, even for DWELL=1.
    function automatic int cnt_width(input int dwell);
        return (clog2(dwell) < 1) ? 1 : clog2(dwell);
    endfunction

endpackage

// File: rtl/onehot_dec.sv
// Combinational N-to-2^N one-hot decoder with enable.
// Output is all-zero while disabled.
module onehot_dec #(
    parameter int N = 2
) (
    input  logic           en,
    input  logic [N-1:0]   sel,
    output logic [2**N-1:0] y
);

    always_comb begin
        y = '0;
        if (en) y[sel] = 1'b1;
    end

endmodule

// File: rtl/scan_decoder.sv
// Registered one-hot decoder with direct and auto-scan modes.
// Define SCAN_BLANK_EN to insert one blank cycle on every scan advance.
module scan_decoder
    import decoder_pkg::*;
#(
    parameter int N     = 2,
    parameter int DWELL = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            mode,
    input  logic [N-1:0]    sel,
    output logic [2**N-1:0] y,
    output logic [N-1:0]    idx,
    output logic            valid,
    output logic            wrap
);

    localparam int CW = cnt_width(DWELL);
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);
`ifdef SCAN_BLANK_EN
    localparam logic BLANK = 1'b1;
`else
    localparam logic BLANK = 1'b0;
`endif

    state_t           state_q, state_d;
    logic [N-1:0]     idx_q, idx_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             blank_q, blank_d;
    logic             wrap_q, wrap_d;
    logic             valid_q;
    logic             show;
    logic [2**N-1:0]  y_q, y_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            blank_q <= 1'b0;
            wrap_q  <= 1'b0;
            valid_q <= 1'b0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            blank_q <= blank_d;
            wrap_q  <= wrap_d;
            valid_q <= show;
            y_q     <= y_d;
        end
    end

    always_comb begin
        state_d = ST_IDLE;
        idx_d   = idx_q;
        cnt_d   = '0;
        blank_d = 1'b0;
        wrap_d  = 1'b0;
        show    = 1'b0;
        if (en) begin
            state_d = (mode == MODE_SCAN) ? ST_SCAN : ST_DIRECT;
        end
        unique case (state_d)
            ST_DIRECT: begin
                idx_d = sel;
                show  = 1'b1;
            end
            ST_SCAN: begin
                if (state_q != ST_SCAN) begin
                    idx_d = sel;
                    show  = 1'b1;
                end else if (blank_q) begin
                    show = 1'b1;
                end else if (cnt_q == LAST) begin
                    // idx rolls over exactly when it is all ones
                    idx_d   = idx_q + 1'b1;
                    wrap_d  = &idx_q;
                    show    = ~BLANK;
                    blank_d = BLANK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    show  = 1'b1;
                end
            end
            default: begin
                show = 1'b0;
            end
        endcase
    end

    onehot_dec #(.N(N)) u_dec (
        .en  (show),
        .sel (idx_d),
        .y   (y_d)
    );

    assign y     = y_q;
    assign idx   = idx_q;
    assign valid = valid_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Self-checking bench for scan_decoder, N=3 with DWELL=4 and DWELL=1.
// Vector table, directed corner sequences and random stimulus vs a model.
module tb_scan_decoder;

`ifdef SCAN_BLANK_EN
    localparam int BL = 1;
`else
    localparam int BL = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       mode = 1'b0;
    logic [2:0] sel = 3'd0;

    logic [7:0] y4, y1;
    logic [2:0] idx4, idx1;
    logic       valid4, valid1, wrap4, wrap1;

    int vectors = 0;
    int errors = 0;

    // model state: 0 idle, 1 direct, 2 scan
    int mst = 0;
    int k = 0;
    int start = 0;
    int dw[2] = '{4, 1};
    int midx[2] = '{0, 0};
    int ey[2], ev[2], ew[2];

    always #5 clk = ~clk;

    scan_decoder #(.N(3), .DWELL(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel),
        .y(y4), .idx(idx4), .valid(valid4), .wrap(wrap4)
    );

    scan_decoder #(.N(3), .DWELL(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel),
        .y(y1), .idx(idx1), .valid(valid1), .wrap(wrap1)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mst = 0;
        k = 0;
        for (int i = 0; i < 2; i++) begin
            midx[i] = 0; ey[i] = 0; ev[i] = 0; ew[i] = 0;
        end
    endtask

    // Scan position from elapsed cycles since entry.
    task automatic model_clock();
        int p, s, o;
        if (!en) mst = 0;
        else if (!mode) mst = 1;
        else begin
            if (mst == 2) k++;
            else begin k = 0; start = sel; end
            mst = 2;
        end
        for (int i = 0; i < 2; i++) begin
            ew[i] = 0;
            if (mst == 0) begin
                ev[i] = 0;
            end else if (mst == 1) begin
                midx[i] = sel;
                ev[i] = 1;
            end else begin
                p = dw[i] + BL;
                s = k / p;
                o = k % p;
                if (o < dw[i]) begin
                    midx[i] = (start + s) % 8;
                    ev[i] = 1;
                    ew[i] = (BL == 0 && s > 0 && o == 0 && midx[i] == 0);
                end else begin
                    midx[i] = (start + s + 1) % 8;
                    ev[i] = 0;
                    ew[i] = (midx[i] == 0);
                end
            end
            ey[i] = ev[i] ? (1 << midx[i]) : 0;
        end
    endtask

    task automatic check_all();
        chk("y4", y4, ey[0]);
        chk("idx4", idx4, midx[0]);
        chk("valid4", valid4, ev[0]);
        chk("wrap4", wrap4, ew[0]);
        chk("y1", y1, ey[1]);
        chk("idx1", idx1, midx[1]);
        chk("valid1", valid1, ev[1]);
        chk("wrap1", wrap1, ew[1]);
        chk("onehot4", (y4 == 0) || $onehot(y4), 1);
        chk("onehot1", (y1 == 0) || $onehot(y1), 1);
    endtask

    task automatic step(input logic e, input logic m, input logic [2:0] s);
        en = e;
        mode = m;
        sel = s;
        @(posedge clk);
        model_clock();
        @(negedge clk);
        check_all();
    endtask

    typedef struct {
        logic       e;
        logic       m;
        logic [2:0] s;
        logic [7:0] ey;
        logic [2:0] ei;
        logic       ev;
        logic       ew;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int w1, w2, ent, fw;
        logic cm;

        tbl[0]  = '{1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 3'd5, 8'h20, 3'd5, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 3'd2, 8'h04, 3'd2, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 3'd2, 8'h00, 3'd2, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 3'd6, 8'h40, 3'd6, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 3'd1, 8'h40, 3'd6, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 3'd3, 8'h40, 3'd6, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 3'd0, 8'h40, 3'd6, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 3'd7, 8'h80, 3'd7, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 3'd2, 8'h04, 3'd2, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 3'd2, 8'h00, 3'd2, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 3'd0, 8'h01, 3'd0, 1'b1, 1'b0};

        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_y", y4, 0);
        chk("rst_valid", valid4, 0);
        rst_n = 1'b1;
        step(0, 0, 0);
        step(0, 0, 3);

        for (int i = 0; i < 12; i++) begin
            step(tbl[i].e, tbl[i].m, tbl[i].s);
            chk($sformatf("tbl%0d_y", i), y4, tbl[i].ey);
            chk($sformatf("tbl%0d_idx", i), idx4, tbl[i].ei);
            chk($sformatf("tbl%0d_valid", i), valid4, tbl[i].ev);
            chk($sformatf("tbl%0d_wrap", i), wrap4, tbl[i].ew);
        end

        // scan from 6: wrap spacing on the DWELL=4 instance
        step(0, 0, 0);
        w1 = -1;
        w2 = -1;
        for (int c = 0; c < 60; c++) begin
            step(1, 1, 3'($urandom_range(0, 7)) | ((c == 0) ? 3'd6 : 3'd0));
            if (wrap4 && w1 < 0) w1 = c;
            else if (wrap4 && w2 < 0) w2 = c;
        end
        chk("wrap_period", w2 - w1, 8 * (4 + BL));

        // DWELL=1 from sel=0: no wrap at entry, first wrap later
        step(0, 0, 0);
        fw = -1;
        for (int c = 0; c < 20; c++) begin
            step(1, 1, 0);
            if (wrap1 && fw < 0) fw = c;
        end
        chk("d1_first_wrap", fw, (BL != 0) ? 15 : 8);

        // mode switch mid-scan
        step(0, 0, 0);
        step(1, 1, 3);
        step(1, 1, 0);
        step(1, 1, 0);
        chk("ms_idx", idx4, 3);
        step(1, 0, 1);
        chk("ms_direct_y", y4, 8'h02);
        for (int c = 0; c < 4; c++) begin
            step(1, 1, (c == 0) ? 3'd1 : 3'd6);
            chk("ms_restart_idx", idx4, 1);
        end
        step(1, 1, 0);
        chk("ms_advance", idx4, 2);
        step(0, 1, 0);
        chk("ms_en_drop_y", y4, 0);

        // asynchronous reset mid-scan
        step(1, 1, 4);
        step(1, 1, 4);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_y4", y4, 0);
        chk("arst_idx4", idx4, 0);
        chk("arst_valid4", valid4, 0);
        chk("arst_wrap4", wrap4, 0);
        chk("arst_y1", y1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 1, 5);
        step(0, 0, 5);

        // random stimulus against the model
        cm = 1'b1;
        for (int c = 0; c < 500; c++) begin
            if ($urandom_range(0, 19) == 0) cm = ~cm;
            step($urandom_range(0, 24) != 0, cm, 3'($urandom_range(0, 7)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/scan_decoder.md
Name: scan_decoder

Overview:
Parametrised N-to-2^N one-hot decoder with registered outputs and two operating modes.
- Direct mode: decodes the select input.
- Scan mode: walks the active output through every index with a programmable dwell time.
Used for digit/row multiplexing, such as LED digit drive and keypad row strobes, and as the general-purpose successor to the fixed combinational 2-to-4 decoder.

Parameters:
N, 2, select width; output width is 2^N (N >= 1).
DWELL, 4, clock cycles each index stays active in scan mode (DWELL >= 1).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
en  input  1  block enable; 0 forces all outputs inactive.
mode  input  1  0 = direct decode, 1 = auto-scan.
sel  input  N  direct-mode index; scan-mode start index.
y  output  2^N  registered one-hot output; y[i] high selects index i.
idx  output  N  index currently driven on y.
valid  output  1  high when y carries an active one-hot code.
wrap  output  1  one-cycle pulse when scan advances from index 2^N-1 to 0.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, y=0, idx=0, valid=0, wrap=0, dwell counter=0. Deassertion of reset is taken synchronously on the next clk edge.
- States: IDLE, DIRECT, SCAN. Transitions are evaluated every rising edge:
  - en=0 -> IDLE
  - en=1, mode=0 -> DIRECT
  - en=1, mode=1 -> SCAN
- IDLE outputs: y=0, valid=0, wrap=0. idx holds its last value.
- DIRECT mode:
  - Latency is 1 cycle: y <= onehot(sel), idx <= sel, valid <= 1.
  - sel is re-sampled every cycle, so a sel change appears on y one cycle later.
- SCAN entry (from IDLE or DIRECT): idx <= sel, y <= onehot(sel), valid <= 1, dwell counter <= 0.
- SCAN progression:
  - Dwell counter increments each cycle.
  - When the counter reaches DWELL-1, it clears and idx <= idx+1, modulo 2^N.
  - Each index is therefore held exactly DWELL cycles.
  - sel is ignored while in SCAN.
- Wrap: asserted for exactly the one cycle in which idx becomes 0 through increment. It is not asserted when scan starts at sel=0.
- DWELL=1: idx advances every cycle, and wrap pulses once every 2^N cycles.
- Mode change mid-scan to DIRECT: next cycle y=onehot(sel), dwell counter cleared. Returning to SCAN restarts from the current sel and does not resume.
- en dropped mid-scan: next cycle IDLE, y=0, dwell counter cleared.
- Reset mid-operation: all outputs go to reset values immediately, without waiting for clk.
- Invariant: y is always all-zero or exactly one-hot. valid == (y != 0), except during blank cycles (see Optional Feature).
- Dwell counter width is clog2(DWELL), minimum 1 bit. Index arithmetic is N-bit unsigned and wraps naturally.

Optional Feature:
SCAN_BLANK_EN
- Defined:
  - In SCAN, each index advance inserts one blank cycle (y=0, valid=0, idx already updated) before the new one-hot appears.
  - The blank is anti-ghosting for multiplexed LED drive.
  - Per-index period becomes DWELL+1 cycles: DWELL active plus 1 blank.
  - wrap coincides with the blank cycle preceding index 0.
  - Scan entry has no blank.
- Undefined: no blank cycles; behaviour as described above.

Decomposition:
- Shared package/include decoder_pkg:
  - State encodings ST_IDLE=2'd0, ST_DIRECT=2'd1, ST_SCAN=2'd2.
  - Mode constants MODE_DIRECT=1'b0, MODE_SCAN=1'b1.
  - clog2 helper function.
- One sub-module onehot_dec, parameter N: purely combinational sel -> 2^N one-hot, with an enable input; output is zero when disabled. scan_decoder registers its output.

Test Plan (N=3, DWELL=4 unless noted):
- Reset: assert rst_n=0 mid-cycle while in SCAN -> y=0, valid=0, wrap=0, idx=0 immediately. Release, en=0 -> outputs stay 0.
- Direct: en=1, mode=0, sel=5 -> next cycle y=8'b0010_0000, idx=5, valid=1. Change sel to 2 -> one cycle later y=8'b0000_0100.
- Scan: en=1, mode=1, sel=6 -> idx sequence 6,6,6,6,7,7,7,7,0,... ; wrap=1 only on the first cycle of idx=0; period of 32 cycles between wraps.
- DWELL=1 (re-parameterised): scan from sel=0 -> idx increments every cycle; first wrap 8 cycles after entry; no wrap on entry.
- Mode switch: SCAN at idx=3 with dwell count 2, set mode=0, sel=1 -> next cycle y=8'b0000_0010. Set mode=1 -> scan restarts at idx=1 with a full 4-cycle dwell. Drop en -> y=0 next cycle.
- With SCAN_BLANK_EN, scan from sel=0 -> pattern of 4 cycles y=onehot(0), 1 cycle y=0 with idx=1, then 4 cycles y=onehot(1). Check the one-hot/zero invariant every cycle.
